// File: rtl/iod_link_pkg.sv
// iod_link_pkg: shared states and constants for the RX link controller.
package iod_link_pkg;
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PLL_WAIT = 3'd1,
      IOD_RST  = 3'd2,
      TRAIN    = 3'd3,
      VERIFY   = 3'd4,
      LINK_UP  = 3'd5,
      RETRY    = 3'd6,
      FAIL     = 3'd7
   } state_t;
   localparam int RST_CYCLES  = 16;
   localparam int SYNC_STAGES = 2;
   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/iod_rx_link_ctrl_if.sv
// iod_rx_link_ctrl_if: lane-side signals of the link controller.
// master = controller (drives *_o), slave = PLL/IOD/PRBS environment (drives *_i).
interface iod_rx_link_ctrl_if #(parameter int CNT_W = 16);
   logic             start_i;
   logic             pll_lock_i;
   logic             train_done_i;
   logic             train_error_i;
   logic             prbs_err_i;
   logic             iod_arst_n_o;
   logic             train_restart_o;
   logic             prbs_en_o;
   logic             link_up_o;
   logic             fail_o;
   logic [3:0]       retry_cnt_o;
   logic [CNT_W-1:0] err_cnt_o;
   logic [2:0]       state_o;
   modport master (
      input  start_i, pll_lock_i, train_done_i, train_error_i, prbs_err_i,
      output iod_arst_n_o, train_restart_o, prbs_en_o, link_up_o, fail_o,
             retry_cnt_o, err_cnt_o, state_o
   );
   modport slave (
      output start_i, pll_lock_i, train_done_i, train_error_i, prbs_err_i,
      input  iod_arst_n_o, train_restart_o, prbs_en_o, link_up_o, fail_o,
             retry_cnt_o, err_cnt_o, state_o
   );
endinterface

// File: rtl/iod_link_sync2.sv
// iod_link_sync2: multi-flop synchronizer for one asynchronous level input.
// Ports: i_clk clock, i_rst async active-high reset (output resets to 0),
//        i_d asynchronous input, o_q synchronized output.
module iod_link_sync2
   import iod_link_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);
   logic [SYNC_STAGES-1:0] r_sync;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
   assign o_q = r_sync[SYNC_STAGES-1];
endmodule

// File: rtl/iod_rx_link_ctrl.sv
// iod_rx_link_ctrl: PF_IOD RX lane bring-up, training, PRBS verify and supervision.
// Ports: clk_i fabric clock, rst_i async active-high reset,
//        bus (master) start/lock/train/prbs inputs; ARST_N, restart pulse,
//        PRBS enable, link/fail status, retry/error counters, debug state.
module iod_rx_link_ctrl
   import iod_link_pkg::*;
#(
   parameter int LOCK_WAIT     = 1024,
   parameter int TRAIN_TIMEOUT = 65536,
   parameter int PRBS_WINDOW   = 4096,
   parameter int ERR_THRESH    = 1,
   parameter int MAX_RETRY     = 3,
   parameter int CNT_W         = 16
)(
   input  logic clk_i,
   input  logic rst_i,
   iod_rx_link_ctrl_if.master bus
);
   localparam int TW = $clog2(imax(imax(LOCK_WAIT, TRAIN_TIMEOUT), imax(PRBS_WINDOW, RST_CYCLES)));
   localparam logic [TW-1:0] LW_END = TW'(LOCK_WAIT - 1);
   localparam logic [TW-1:0] TT_END = TW'(TRAIN_TIMEOUT - 1);
   localparam logic [TW-1:0] PW_END = TW'(PRBS_WINDOW - 1);
   localparam logic [TW-1:0] RC_END = TW'(RST_CYCLES - 1);
   logic w_lock_s, w_done_s, w_terr_s, w_perr_s;
   state_t r_state, w_state_d;
   logic [TW-1:0] r_tmr, w_tmr_d;
   logic [3:0] r_retry;
   logic [CNT_W-1:0] r_err, w_err_inc;
   logic r_arst_n, r_restart, r_prbs_en, r_link_up, r_fail;
   iod_link_sync2 u_sync_lock (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.pll_lock_i),    .o_q(w_lock_s));
   iod_link_sync2 u_sync_done (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.train_done_i),  .o_q(w_done_s));
   iod_link_sync2 u_sync_terr (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.train_error_i), .o_q(w_terr_s));
   iod_link_sync2 u_sync_perr (.i_clk(clk_i), .i_rst(rst_i), .i_d(bus.prbs_err_i),    .o_q(w_perr_s));
   assign w_err_inc = (r_err == '1) ? r_err : r_err + CNT_W'(w_perr_s);
   always_comb begin
      w_state_d = r_state;
      if (!bus.start_i)
         w_state_d = IDLE;
      else if (!w_lock_s && (r_state inside {IOD_RST, TRAIN, VERIFY, LINK_UP}))
         w_state_d = PLL_WAIT;
      else
         case (r_state)
            IDLE:     w_state_d = PLL_WAIT;
            PLL_WAIT: if (w_lock_s && r_tmr == LW_END) w_state_d = IOD_RST;
            IOD_RST:  if (r_tmr == RC_END) w_state_d = TRAIN;
            TRAIN:    w_state_d = (w_terr_s || r_tmr == TT_END) ? RETRY : w_done_s ? VERIFY : TRAIN;
            VERIFY:   if (!w_done_s) w_state_d = RETRY;
                      else if (r_tmr == PW_END)
                         w_state_d = (32'(w_err_inc) >= 32'(ERR_THRESH)) ? RETRY : LINK_UP;
            LINK_UP:  if (!w_done_s || w_terr_s) w_state_d = RETRY;
            RETRY:    w_state_d = (r_retry == 4'(MAX_RETRY)) ? FAIL : IOD_RST;
            default:  w_state_d = FAIL;
         endcase
   end
   // The shared timer restarts on every state entry; in PLL_WAIT it also
   // restarts whenever lock drops so only continuous lock is counted.
   assign w_tmr_d = (w_state_d != r_state || (r_state == PLL_WAIT && !w_lock_s)) ? '0 : r_tmr + 1'b1;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_state <= IDLE;
         r_tmr   <= '0;
      end else begin
         r_state <= w_state_d;
         r_tmr   <= w_tmr_d;
      end
   // Outputs are decoded from the next state so they update on the same edge as state_o.
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         r_retry   <= '0;
         r_err     <= '0;
         r_arst_n  <= 1'b0;
         r_restart <= 1'b0;
         r_prbs_en <= 1'b0;
         r_link_up <= 1'b0;
         r_fail    <= 1'b0;
      end else begin
         r_retry   <= (w_state_d == IDLE) ? '0 : (r_state == RETRY && w_state_d == IOD_RST) ? r_retry + 1'b1 : r_retry;
         r_err     <= (w_state_d == IDLE || (w_state_d == VERIFY && r_state != VERIFY)) ? '0 :
                      (r_state inside {VERIFY, LINK_UP}) ? w_err_inc : r_err;
         r_arst_n  <= w_state_d inside {TRAIN, VERIFY, LINK_UP};
         r_restart <= w_state_d == TRAIN && r_state != TRAIN;
         r_prbs_en <= w_state_d inside {VERIFY, LINK_UP};
         r_link_up <= w_state_d == LINK_UP;
         r_fail    <= w_state_d == FAIL;
      end
   assign bus.iod_arst_n_o    = r_arst_n;
   assign bus.train_restart_o = r_restart;
   assign bus.prbs_en_o       = r_prbs_en;
   assign bus.link_up_o       = r_link_up;
   assign bus.fail_o          = r_fail;
   assign bus.retry_cnt_o     = r_retry;
   assign bus.err_cnt_o       = r_err;
   assign bus.state_o         = r_state;
endmodule

// File: tb/tb_iod_rx_link_ctrl.sv
// tb_iod_rx_link_ctrl: scoreboard bench for the RX link controller.
module tb_iod_rx_link_ctrl;
   import iod_link_pkg::*;
   localparam int LW = 8, TT = 32, PW = 64, ET = 4, MR = 2, CW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   iod_rx_link_ctrl_if #(.CNT_W(CW)) bus();
   iod_rx_link_ctrl #(
      .LOCK_WAIT(LW), .TRAIN_TIMEOUT(TT), .PRBS_WINDOW(PW),
      .ERR_THRESH(ET), .MAX_RETRY(MR), .CNT_W(CW)
   ) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   int n_chk = 0, n_err = 0, cyc = 0, done_at = -1;
   bit done_en = 0;
   logic [2:0] exp_q[$];
   int pulse_q[$];
   logic [2:0] prev_st = 3'd0;
   logic prev_rs = 1'b0;
   int t0, t1, np;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (bus.state_o != prev_st) begin
         if (exp_q.size() == 0) chk("st_unexp", bus.state_o, prev_st);
         else chk("st_seq", bus.state_o, exp_q.pop_front());
         prev_st = bus.state_o;
      end
      if (bus.train_restart_o) begin
         chk("rs_width", prev_rs, 0);
         pulse_q.push_back(cyc);
         if (done_en) done_at = cyc + 10;
      end
      prev_rs = bus.train_restart_o;
      if (!bus.iod_arst_n_o) bus.train_done_i = 1'b0;
      if (done_en && cyc == done_at) bus.train_done_i = 1'b1;
   endtask
   task automatic wait_st(input logic [2:0] s, input int budget);
      int n = 0;
      while (bus.state_o != s && n < budget) begin
         tick();
         n++;
      end
      if (bus.state_o != s) chk("wait_st", bus.state_o, s);
   endtask
   initial begin
      bus.start_i = 0; bus.pll_lock_i = 0; bus.train_done_i = 0;
      bus.train_error_i = 0; bus.prbs_err_i = 0;
      repeat (3) tick();
      chk("rst_state", bus.state_o, IDLE);
      chk("rst_arst", bus.iod_arst_n_o, 0);
      chk("rst_outs", {bus.train_restart_o, bus.prbs_en_o, bus.link_up_o, bus.fail_o}, 0);
      chk("rst_cnts", {bus.retry_cnt_o, bus.err_cnt_o}, 0);
      rst = 0;
      // nominal bring-up
      bus.pll_lock_i = 1;
      repeat (3) tick();
      done_en = 1;
      exp_q = '{PLL_WAIT, IOD_RST, TRAIN, VERIFY, LINK_UP};
      bus.start_i = 1;
      wait_st(PLL_WAIT, 5);
      t0 = cyc;
      wait_st(TRAIN, 100);
      chk("pw_to_train", cyc - t0, LW + RST_CYCLES);
      chk("arst_train", bus.iod_arst_n_o, 1);
      wait_st(VERIFY, 50);
      t0 = cyc;
      chk("prbs_en_v", bus.prbs_en_o, 1);
      wait_st(LINK_UP, 200);
      chk("verify_len", cyc - t0, PW);
      chk("link_up", bus.link_up_o, 1);
      chk("err_nom", bus.err_cnt_o, 0);
      chk("pulses_nom", pulse_q.size(), 1);
      // lock loss in LINK_UP
      exp_q.push_back(PLL_WAIT);
      bus.pll_lock_i = 0;
      repeat (3) tick();
      chk("ll_link", bus.link_up_o, 0);
      chk("ll_state", bus.state_o, PLL_WAIT);
      chk("ll_retry", bus.retry_cnt_o, 0);
      // relock, then fail the verify window
      exp_q = '{IOD_RST, TRAIN, VERIFY, RETRY, IOD_RST, TRAIN, VERIFY, LINK_UP};
      bus.pll_lock_i = 1;
      wait_st(VERIFY, 100);
      repeat (5) tick();
      bus.prbs_err_i = 1;
      repeat (4) tick();
      bus.prbs_err_i = 0;
      wait_st(RETRY, 200);
      chk("vf_err", bus.err_cnt_o, 4);
      np = pulse_q.size();
      tick();
      chk("vf_retry", bus.retry_cnt_o, 1);
      chk("vf_arst", bus.iod_arst_n_o, 0);
      t0 = cyc;
      wait_st(TRAIN, 50);
      chk("vf_rst_len", cyc - t0, RST_CYCLES);
      chk("vf_pulse", pulse_q.size(), np + 1);
      wait_st(LINK_UP, 200);
      chk("vf_link", bus.link_up_o, 1);
      // error counter saturation in LINK_UP
      bus.prbs_err_i = 1;
      repeat (20) tick();
      chk("sat_err", bus.err_cnt_o, 15);
      chk("sat_state", bus.state_o, LINK_UP);
      bus.prbs_err_i = 0;
      // simultaneous train done and error
      exp_q.push_back(IDLE);
      bus.start_i = 0;
      wait_st(IDLE, 5);
      chk("idle_clr", {bus.retry_cnt_o, bus.err_cnt_o}, 0);
      done_en = 0;
      exp_q = '{PLL_WAIT, IOD_RST, TRAIN, RETRY, IOD_RST, IDLE};
      bus.start_i = 1;
      wait_st(TRAIN, 100);
      repeat (4) tick();
      bus.train_done_i = 1;
      bus.train_error_i = 1;
      wait_st(RETRY, 10);
      tick();
      chk("sim_retry", bus.retry_cnt_o, 1);
      bus.train_error_i = 0;
      bus.start_i = 0;
      wait_st(IDLE, 5);
      // train timeout until retries are exhausted
      pulse_q.delete();
      exp_q = '{PLL_WAIT, IOD_RST, TRAIN, RETRY, IOD_RST, TRAIN, RETRY, IOD_RST, TRAIN, RETRY, FAIL};
      bus.start_i = 1;
      wait_st(FAIL, 500);
      chk("to_pulses", pulse_q.size(), 3);
      if (pulse_q.size() == 3) begin
         chk("to_gap1", pulse_q[1] - pulse_q[0], TT + RST_CYCLES + 1);
         chk("to_gap2", pulse_q[2] - pulse_q[1], TT + RST_CYCLES + 1);
      end
      chk("fail", bus.fail_o, 1);
      chk("fail_retry", bus.retry_cnt_o, MR);
      chk("fail_arst", bus.iod_arst_n_o, 0);
      repeat (5) tick();
      chk("fail_hold", bus.state_o, FAIL);
      exp_q = '{IDLE, PLL_WAIT};
      bus.start_i = 0;
      tick();
      chk("fail_clr", {bus.fail_o, bus.retry_cnt_o}, 0);
      bus.start_i = 1;
      tick();
      chk("restart_pw", bus.state_o, PLL_WAIT);
      // asynchronous reset during TRAIN
      exp_q = '{IOD_RST, TRAIN, IDLE};
      wait_st(TRAIN, 100);
      repeat (2) tick();
      rst = 1;
      bus.start_i = 0;
      #1;
      chk("ar_state", bus.state_o, IDLE);
      chk("ar_outs", {bus.iod_arst_n_o, bus.train_restart_o, bus.prbs_en_o, bus.link_up_o, bus.fail_o}, 0);
      chk("ar_cnts", {bus.retry_cnt_o, bus.err_cnt_o}, 0);
      np = pulse_q.size();
      repeat (3) tick();
      rst = 0;
      repeat (5) tick();
      chk("ar_no_pulse", pulse_q.size(), np);
      chk("sb_left", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
